// File: rtl/board_scanner_pkg.sv
// connect4_pkg: board geometry, cell codes, line directions and scanner states
// shared by the board reader and its line checker.
package connect4_pkg;
    localparam int ROWS = 7;
    localparam int COLS = 7;
    localparam int CELLS = ROWS * COLS;
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1 = 2'b01;
    localparam logic [1:0] P2 = 2'b10;
    localparam logic [1:0] P3 = 2'b11;
    typedef enum logic [1:0] {DIR_RIGHT, DIR_DOWN, DIR_DR, DIR_DL} dir_t;
    typedef enum logic [2:0] {IDLE, READ, DRAIN, SCAN, DONE} state_t;
    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
    } rc_t;
    function automatic rc_t cell_rc(input logic [5:0] idx);
        return '{row: 3'(idx / 6'(COLS)), col: 3'(idx % 6'(COLS))};
    endfunction
    function automatic int dir_step(input int d);
        return d == 0 ? 1 : d == 1 ? COLS : d == 2 ? COLS + 1 : COLS - 1;
    endfunction
endpackage

// File: rtl/board_scanner_if.sv
// board_scanner_if: RAM read port, start/status handshake and scan results.
interface board_scanner_if;
    logic       start;
    logic       rd_en;
    logic [5:0] rd_addr;
    logic [1:0] rd_data;
    logic       busy;
    logic       done;
    logic [1:0] winner;
    logic [5:0] win_cell;
    logic [1:0] win_dir;
    logic [6:0] col_full;
    logic       board_full;
    modport master (input start, rd_data,
                    output rd_en, rd_addr, busy, done, winner, win_cell, win_dir, col_full, board_full);
    modport slave (output start, rd_data,
                   input rd_en, rd_addr, busy, done, winner, win_cell, win_dir, col_full, board_full);
endinterface

// File: rtl/board_scanner_line_checker.sv
// line_checker: four-in-a-row test from one anchor cell in all four directions.
module line_checker
    import connect4_pkg::*;
(
    input  logic [97:0]     i_image,
    input  logic [5:0]      i_cell,
    output logic [3:0]      o_hit,
    output logic [3:0][1:0] o_code
);
    rc_t                   w_rc;
    logic [3:0]            w_ok;
    logic [3:0][3:0][1:0]  w_cell;
    function automatic logic [1:0] cell_at(input logic [97:0] img, input logic [6:0] k);
        return (k < 7'(CELLS)) ? img[{k[5:0], 1'b0} +: 2] : EMPTY;
    endfunction
    assign w_rc = cell_rc(i_cell);
    // Bounds per direction: right, down, down-right, down-left; no wrap across rows.
    assign w_ok = {w_rc.col >= 3'(COLS - 4) && w_rc.row <= 3'(ROWS - 4),
                   w_rc.col <= 3'(COLS - 4) && w_rc.row <= 3'(ROWS - 4),
                   w_rc.row <= 3'(ROWS - 4),
                   w_rc.col <= 3'(COLS - 4)};
    always_comb begin
        for (int d = 0; d < 4; d++) begin
            for (int n = 0; n < 4; n++)
                w_cell[d][n] = cell_at(i_image, 7'(i_cell) + 7'(n * dir_step(d)));
            o_code[d] = w_cell[d][0];
            o_hit[d] = w_ok[d] && w_cell[d][0] != EMPTY && w_cell[d][1] == w_cell[d][0]
                       && w_cell[d][2] == w_cell[d][0] && w_cell[d][3] == w_cell[d][0];
        end
    end
endmodule

// File: rtl/board_scanner.sv
// board_scanner: reads the 49-cell board out of RAM into a local image, then
// scans it cell by cell for the first four-in-a-row and reports fill status.
module board_scanner
    import connect4_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input logic CLOCK_50,
    input logic reset,
    board_scanner_if.master bus
);
    state_t           r_state;
    logic [97:0]      r_image;
    logic [5:0]       r_rd_addr;
    logic [5:0]       r_cap;
    logic [5:0]       r_idx;
    logic [RD_LAT-1:0] r_vld;
    logic             r_rd_en;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_winner;
    logic [5:0]       r_win_cell;
    logic [1:0]       r_win_dir;
    logic [6:0]       r_col_full;
    logic             r_board_full;
    logic [3:0]       w_hit;
    logic [3:0][1:0]  w_code;
    dir_t             w_dir;
    logic [6:0]       w_col_full;
    logic [CELLS-1:0] w_nz;
    logic             w_cap;
    line_checker u_chk (.i_image(r_image), .i_cell(r_idx), .o_hit(w_hit), .o_code(w_code));
    assign w_cap = r_vld[RD_LAT-1];
    always_comb begin
        w_dir = w_hit[0] ? DIR_RIGHT : w_hit[1] ? DIR_DOWN : w_hit[2] ? DIR_DR : DIR_DL;
        for (int k = 0; k < CELLS; k++) w_nz[k] = r_image[2*k +: 2] != EMPTY;
        w_col_full = w_nz[COLS-1:0];
    end
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_image <= '0;
            r_rd_addr <= '0;
            r_cap <= '0;
            r_idx <= '0;
            r_vld <= '0;
            r_rd_en <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_winner <= '0;
            r_win_cell <= '0;
            r_win_dir <= '0;
            r_col_full <= '0;
            r_board_full <= 1'b0;
        end else begin
            // Read-enable delay line marks the cycle each requested cell arrives.
            r_vld <= RD_LAT'({r_vld, r_rd_en});
            if (w_cap) begin
                r_image[{r_cap, 1'b0} +: 2] <= bus.rd_data;
                r_cap <= r_cap + 6'd1;
            end
            case (r_state)
                IDLE: if (bus.start) begin
                    r_state <= READ;
                    r_image <= '0;
                    r_cap <= '0;
                    r_rd_en <= 1'b1;
                    r_rd_addr <= '0;
                    r_busy <= 1'b1;
                    r_winner <= '0;
                    r_win_cell <= '0;
                    r_win_dir <= '0;
                    r_col_full <= '0;
                    r_board_full <= 1'b0;
                end
                READ: if (r_rd_addr == 6'(CELLS - 1)) begin
                    r_rd_en <= 1'b0;
                    r_rd_addr <= '0;
                    r_state <= DRAIN;
                end else r_rd_addr <= r_rd_addr + 6'd1;
                DRAIN: if (w_cap && r_cap == 6'(CELLS - 1)) begin
                    r_idx <= '0;
                    r_state <= SCAN;
                end
                SCAN: if (|w_hit || r_idx == 6'(CELLS - 1)) begin
                    r_state <= DONE;
                    r_done <= 1'b1;
                    r_winner <= |w_hit ? w_code[w_dir] : EMPTY;
                    r_win_cell <= |w_hit ? r_idx : 6'd0;
                    r_win_dir <= |w_hit ? w_dir : DIR_RIGHT;
                    r_col_full <= w_col_full;
                    r_board_full <= &w_nz;
                end else r_idx <= r_idx + 6'd1;
                DONE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.rd_en = r_rd_en;
    assign bus.rd_addr = r_rd_addr;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.winner = r_winner;
    assign bus.win_cell = r_win_cell;
    assign bus.win_dir = r_win_dir;
    assign bus.col_full = r_col_full;
    assign bus.board_full = r_board_full;
endmodule

// File: tb/tb_board_scanner.sv
// tb_board_scanner: directed board images through an RD_LAT=1 and an RD_LAT=2 scanner
// with a behavioural RAM per instance; expectations are hand-derived.
module tb_board_scanner;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic sel_b = 1'b0;
    int vecs = 0;
    int errs = 0;
    logic [1:0] ram [64];
    logic [1:0] a_d1, b_d1, b_d2;
    board_scanner_if ifa ();
    board_scanner_if ifb ();
    board_scanner #(.RD_LAT(1)) dut_a (.CLOCK_50(clk), .reset(rst_a), .bus(ifa));
    board_scanner #(.RD_LAT(2)) dut_b (.CLOCK_50(clk), .reset(rst_b), .bus(ifb));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        a_d1 <= ram[ifa.rd_addr];
        b_d1 <= ram[ifb.rd_addr];
        b_d2 <= b_d1;
    end
    assign ifa.rd_data = a_d1;
    assign ifb.rd_data = b_d2;
    logic       m_rd_en, m_busy, m_done, m_bf;
    logic [5:0] m_rd_addr, m_cell;
    logic [1:0] m_winner, m_dir;
    logic [6:0] m_cf;
    assign m_rd_en   = sel_b ? ifb.rd_en : ifa.rd_en;
    assign m_rd_addr = sel_b ? ifb.rd_addr : ifa.rd_addr;
    assign m_busy    = sel_b ? ifb.busy : ifa.busy;
    assign m_done    = sel_b ? ifb.done : ifa.done;
    assign m_winner  = sel_b ? ifb.winner : ifa.winner;
    assign m_cell    = sel_b ? ifb.win_cell : ifa.win_cell;
    assign m_dir     = sel_b ? ifb.win_dir : ifa.win_dir;
    assign m_cf      = sel_b ? ifb.col_full : ifa.col_full;
    assign m_bf      = sel_b ? ifb.board_full : ifa.board_full;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_ram();
        for (int k = 0; k < 64; k++) ram[k] = 2'b00;
    endtask

    task automatic put4(input int a, input int step, input logic [1:0] v);
        for (int n = 0; n < 4; n++) ram[a + n * step] = v;
    endtask

    task automatic run(input string tag, input bit b, input int exp_done, input logic [1:0] ew,
                       input logic [5:0] ec, input logic [1:0] ed, input logic [6:0] ecf, input logic ebf);
        int dcyc;
        bit sweep_ok, busy_ok;
        sweep_ok = 1'b1;
        busy_ok = 1'b1;
        dcyc = -1;
        sel_b = b;
        @(posedge clk); #1;
        if (b) ifb.start = 1'b1; else ifa.start = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        chk({tag, " cleared_at_start"}, 32'(m_winner), 32'd0);
        for (int cyc = 1; cyc <= 200 && dcyc < 0; cyc++) begin
            if (cyc <= 49 && !(m_rd_en === 1'b1 && m_rd_addr === 6'(cyc - 1))) sweep_ok = 1'b0;
            if (cyc >= 50 && m_rd_en !== 1'b0) sweep_ok = 1'b0;
            if (m_busy !== 1'b1) busy_ok = 1'b0;
            if (m_done === 1'b1) dcyc = cyc;
            else begin
                @(posedge clk); #1;
            end
        end
        chk({tag, " done_cycle"}, 32'(dcyc), 32'(exp_done));
        chk({tag, " rd_sweep"}, 32'(sweep_ok), 32'd1);
        chk({tag, " busy"}, 32'(busy_ok), 32'd1);
        chk({tag, " winner"}, 32'(m_winner), 32'(ew));
        chk({tag, " win_cell"}, 32'(m_cell), 32'(ec));
        chk({tag, " win_dir"}, 32'(m_dir), 32'(ed));
        chk({tag, " col_full"}, 32'(m_cf), 32'(ecf));
        chk({tag, " board_full"}, 32'(m_bf), 32'(ebf));
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, 32'({m_done, m_busy}), 32'd0);
        chk({tag, " hold"}, 32'({m_winner, m_cell, m_dir}), 32'({ew, ec, ed}));
    endtask

    initial begin
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        clear_ram();
        repeat (3) @(posedge clk);
        #1;
        chk("rst rd_en", 32'(ifa.rd_en), 32'd0);
        chk("rst rd_addr", 32'(ifa.rd_addr), 32'd0);
        chk("rst busy_done", 32'({ifa.busy, ifa.done}), 32'd0);
        chk("rst result", 32'({ifa.winner, ifa.win_cell, ifa.win_dir}), 32'd0);
        chk("rst full", 32'({ifa.col_full, ifa.board_full}), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        run("empty", 1'b0, 100, 2'b00, 6'd0, 2'd0, 7'b0000000, 1'b0);
        put4(42, 1, 2'b01);
        run("bottom_row", 1'b0, 94, 2'b01, 6'd42, 2'd0, 7'b0000000, 1'b0);
        clear_ram();
        put4(3, 6, 2'b10);
        run("down_left", 1'b0, 55, 2'b10, 6'd3, 2'd3, 7'b0001000, 1'b0);
        clear_ram();
        put4(0, 8, 2'b01);
        run("down_right", 1'b0, 52, 2'b01, 6'd0, 2'd2, 7'b0000001, 1'b0);
        clear_ram();
        put4(6, 7, 2'b10);
        put4(14, 1, 2'b01);
        run("first_wins", 1'b0, 58, 2'b10, 6'd6, 2'd1, 7'b1000000, 1'b0);
        clear_ram();
        put4(5, 1, 2'b01);
        run("wrap_guard", 1'b0, 100, 2'b00, 6'd0, 2'd0, 7'b1100000, 1'b0);
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++) ram[r * 7 + c] = 2'(1 + (((c / 2) + r) % 2));
        run("full_draw", 1'b0, 100, 2'b00, 6'd0, 2'd0, 7'b1111111, 1'b1);
        clear_ram();
        put4(42, 1, 2'b01);
        sel_b = 1'b1;
        @(posedge clk); #1;
        ifb.start = 1'b1;
        @(posedge clk); #1;
        ifb.start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("mid_read addr", 32'(ifb.rd_addr), 32'd19);
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk("abort rd", 32'({ifb.rd_en, ifb.rd_addr}), 32'd0);
        chk("abort status", 32'({ifb.busy, ifb.done, ifb.winner, ifb.col_full}), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        ifb.start = 1'b1;
        @(posedge clk); #1;
        ifb.start = 1'b0;
        chk("start_in_reset", 32'({ifb.busy, ifb.rd_en}), 32'd0);
        rst_b = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", 32'({ifb.busy, ifb.rd_en}), 32'd0);
        run("lat2_bottom", 1'b1, 95, 2'b01, 6'd42, 2'd0, 7'b0000000, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
